mem_req_arb: RTL and testbench

Round-robin arbiter that shares one valid/ready request channel among `N` requesters, e.g. instruction fetch, load/store and page-table walker feeding the single memory/bus port. Each winner keeps the channel for a multi-beat burst until its `last` beat. A one-entry registered output stage gives full throughput under back-pressure. Each output beat carries the requester index so the response path can route replies.

---
 rtl/mem_req_arb.sv | 126 ++++++++++++
 tb/tb_mem_req_arb.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arb.sv
// mem_req_arb: round-robin arbiter sharing one valid/ready channel among N requesters,
// with burst lock until the last beat and a one-entry registered output tagged by requester.
//
// state  | meaning
// IDLE   | no burst in progress; grant scans requesters starting at ptr
// LOCKED | owner is mid-burst; only owner may transfer, others wait even on a bubble

module mem_req_arb #(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] req_data,
    input  logic [N-1:0]       req_valid,
    input  logic [N-1:0]       req_last,
    output logic [N-1:0]       req_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [ID_W-1:0]    out_id,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   owner, owner_nxt;
    logic [ID_W-1:0]   ptr, ptr_nxt;

    logic [N-1:0]      grant;
    logic [ID_W-1:0]   gnt_idx;
    logic              found;
    logic              can_load;
    logic              xfer;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_last;

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= N) s = s - N;
        return ID_W'(s);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        if (xfer) begin
            if (sel_last) begin
                state_nxt = IDLE;
                ptr_nxt   = (gnt_idx == ID_W'(N - 1)) ? '0 : gnt_idx + ID_W'(1);
            end else if (state == IDLE) begin
                state_nxt = LOCKED;
                owner_nxt = gnt_idx;
            end
        end
    end

    // Grant never looks at out_ready; back-pressure only gates req_ready via can_load.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        if (state == LOCKED) begin
            gnt_idx      = owner;
            grant[owner] = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!found && req_valid[rr_idx(ptr, k)]) begin
                    found   = 1'b1;
                    gnt_idx = rr_idx(ptr, k);
                end
            end
            grant[gnt_idx] = found;
        end
        if (!rst_n) grant = '0;

        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*WIDTH +: WIDTH];
                sel_last = req_last[i];
            end
        end
    end

    assign can_load  = !out_valid || out_ready;
    assign req_ready = grant & {N{can_load}};
    assign xfer      = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_id    <= gnt_idx;
            out_last  <= sel_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_req_arb.sv
// Bench for mem_req_arb: per-requester burst plans, a burst-level round-robin model
// feeding an expected-beat queue, and a negedge monitor that pops and compares.

module tb_mem_req_arb;

    localparam int W   = 64;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     out_data;
    logic [IDW-1:0]   out_id;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    always #5 clk = ~clk;

    mem_req_arb #(.WIDTH(W), .N(N), .ID_W(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct packed {
        logic [W-1:0]   data;
        logic [IDW-1:0] id;
        logic           last;
    } beat_t;

    int          total = 0;
    int          bad = 0;
    beat_t       exp_q[$];
    logic [W-1:0] pd[N][$];
    bit          pl[N][$];
    int          pos[N];
    int          gap_left[N];
    int          force_at[N];
    bit          gaps_en;
    int          rmode;
    int          model_ptr;
    logic [N-1:0] fire_s;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < N; i++) begin
            pd[i].delete();
            pl[i].delete();
            pos[i] = 0;
            gap_left[i] = 0;
            force_at[i] = -1;
        end
        exp_q.delete();
        req_valid = '0;
    endtask

    task automatic add_beat(input int i, input logic [W-1:0] d, input bit last);
        pd[i].push_back(d);
        pl[i].push_back(last);
    endtask

    task automatic add_burst(input int i, input int len);
        for (int b = 0; b < len; b++) add_beat(i, {$urandom, $urandom}, b == len - 1);
    endtask

    // Whole bursts are granted round-robin among requesters that still have work queued.
    task automatic build_expect();
        int    cur[N];
        int    j;
        int    idx;
        beat_t b;
        for (int i = 0; i < N; i++) cur[i] = 0;
        while (1) begin
            j = -1;
            for (int k = 0; k < N; k++) begin
                idx = (model_ptr + k) % N;
                if (j < 0 && cur[idx] < pd[idx].size()) j = idx;
            end
            if (j < 0) break;
            do begin
                b.data = pd[j][cur[j]];
                b.id   = IDW'(j);
                b.last = pl[j][cur[j]];
                exp_q.push_back(b);
                cur[j]++;
            end while (!pl[j][cur[j]-1]);
            model_ptr = (j + 1) % N;
        end
    endtask

    task automatic run_plan(input bit tput, input int budget);
        int cyc = 0;
        int bub = 0;
        bit started = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
            if (out_valid) started = 1;
            else if (started && exp_q.size() > 0) bub++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d beats outstanding want 0", exp_q.size());
            exp_q.delete();
        end
        if (tput) check("throughput_bubbles", 64'(bub), 64'(0));
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire_s[i]) begin
                pos[i]++;
                if (force_at[i] == pos[i]) gap_left[i] = 2;
                else if (gaps_en && !pl[i][pos[i]-1] && $urandom_range(0, 2) == 0)
                    gap_left[i] = int'($urandom_range(1, 3));
            end else if (gap_left[i] > 0) begin
                gap_left[i]--;
            end
            if (pos[i] < pd[i].size() && gap_left[i] == 0) begin
                req_valid[i]          = 1'b1;
                req_data[i*W +: W]    = pd[i][pos[i]];
                req_last[i]           = pl[i][pos[i]];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        if (rmode == 0) out_ready = 1'b1;
        else if (rmode == 1) out_ready = ($urandom_range(0, 3) != 0);
        fire_s = '0;
    end

    logic          pv, pr, plast, prst;
    logic [W-1:0]  pdata;
    logic [IDW-1:0] pid;
    beat_t         mon_e;

    always @(negedge clk) begin
        fire_s = req_valid & req_ready;
        if (rst_n) begin
            check("ready_onehot0", 64'($onehot0(req_ready)), 64'(1));
            if (out_valid && !out_ready) check("stall_ready", 64'(req_ready), 64'(0));
            if (prst && pv && !pr) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", out_data, pdata);
                check("hold_id", 64'(out_id), 64'(pid));
                check("hold_last", 64'(out_last), 64'(plast));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got id=%0d data=%0h want none", out_id, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_id", 64'(out_id), 64'(mon_e.id));
                    check("beat_data", out_data, mon_e.data);
                    check("beat_last", 64'(out_last), 64'(mon_e.last));
                end
            end
        end
        pv = out_valid; pr = out_ready; pdata = out_data; pid = out_id; plast = out_last;
        prst = rst_n;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b1;
        rmode = 0; gaps_en = 0; model_ptr = 0; fire_s = '0;
        pv = 0; pr = 0; plast = 0; prst = 0; pdata = '0; pid = '0;
        clear_plan();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset in the middle of traffic with every requester valid.
        rmode = 1;
        for (int i = 0; i < N; i++) begin add_burst(i, 4); add_burst(i, 4); end
        build_expect();
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_id", 64'(out_id), 64'(0));
        check("rst_out_data", out_data, 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        clear_plan();
        model_ptr = 0;
        rmode = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Fairness: single beats, all valid, first grant after reset goes to 0.
        add_burst(0, 1); add_burst(0, 1); add_burst(1, 1); add_burst(1, 1);
        add_burst(2, 1); add_burst(3, 1);
        build_expect();
        run_plan(1, 200);

        clear_plan();
        add_burst(0, 1);
        build_expect();
        run_plan(0, 200);

        // Burst lock: 1,1,1,2,0 with last 0,0,1,1,1.
        clear_plan();
        add_burst(1, 3); add_burst(0, 1); add_burst(2, 1);
        build_expect();
        run_plan(1, 200);

        // Back-pressure on a held 0xA5 beat from requester 3.
        clear_plan();
        rmode = 2;
        out_ready = 1'b1;
        add_beat(3, 64'hA5, 1'b1);
        add_burst(0, 1);
        build_expect();
        n = 0;
        do begin @(negedge clk); n++; end while (!(req_valid[3] && req_ready[3]) && n < 50);
        check("bp_accept_seen", 64'(req_valid[3] && req_ready[3]), 64'(1));
        @(posedge clk);
        #2 out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_data", out_data, 64'hA5);
            check("bp_id", 64'(out_id), 64'(3));
            check("bp_ready", 64'(req_ready), 64'(0));
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(negedge clk);
        check("bp_reload_ready", 64'(req_ready), 64'(4'b0001));
        run_plan(0, 200);
        rmode = 0;

        // Owner bubble: requester 2 pauses two cycles mid-burst while 0 waits.
        clear_plan();
        add_burst(2, 4); add_burst(0, 1);
        force_at[2] = 1;
        build_expect();
        n = 0;
        while (gap_left[2] != 2 && n < 50) begin @(posedge clk); #2; n++; end
        check("bubble_seen", 64'(gap_left[2]), 64'(2));
        @(negedge clk);
        check("bubble_ready0_a", 64'(req_ready[0]), 64'(0));
        @(negedge clk);
        check("bubble_valid_b", 64'(out_valid), 64'(0));
        check("bubble_ready0_b", 64'(req_ready[0]), 64'(0));
        @(negedge clk);
        check("bubble_valid_c", 64'(out_valid), 64'(0));
        check("bubble_ready0_c", 64'(req_ready[0]), 64'(0));
        check("bubble_resume2", 64'(req_ready[2]), 64'(1));
        run_plan(0, 200);

        // Reset after the second beat of a 4-beat burst from requester 1.
        clear_plan();
        add_burst(1, 4);
        build_expect();
        n = 0;
        while (pos[1] != 2 && n < 50) begin @(posedge clk); #2; n++; end
        check("midburst_seen", 64'(pos[1]), 64'(2));
        rst_n = 1'b0;
        #1;
        check("midburst_rst_valid", 64'(out_valid), 64'(0));
        check("midburst_rst_ready", 64'(req_ready), 64'(0));
        clear_plan();
        model_ptr = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        add_burst(0, 1); add_burst(1, 1);
        build_expect();
        run_plan(0, 200);

        // Randomized bursts, random back-pressure and owner gaps.
        for (int r = 0; r < 4; r++) begin
            clear_plan();
            gaps_en = 1;
            rmode = 1;
            for (int i = 0; i < N; i++) begin
                n = int'($urandom_range(0, 3));
                for (int b = 0; b < n; b++) add_burst(i, int'($urandom_range(1, 4)));
            end
            build_expect();
            run_plan(0, 2000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
